// File: rtl/dwt_level_sequencer_if.sv
// Sequencer <-> source/datapath/coarse-buffer handshake bundle.
// master: sequencer side; slave: source, datapath and buffer side.
interface dwt_level_sequencer_if #(
  parameter int CNT_W  = 5,
  parameter int ADDR_W = 4
) ();
  logic              in_valid;
  logic              in_ready;
  logic              valid_coarseOut;
  logic [CNT_W-1:0]  count;
  logic              valid_in;
  logic              internal_valid;
  logic              cbuf_rd_en;
  logic [ADDR_W-1:0] cbuf_rd_addr;
  logic              cbuf_wr_en;
  logic [ADDR_W-1:0] cbuf_wr_addr;

  modport master (
    input  in_valid, valid_coarseOut,
    output in_ready, count, valid_in, internal_valid,
    output cbuf_rd_en, cbuf_rd_addr, cbuf_wr_en, cbuf_wr_addr
  );

  modport slave (
    output in_valid, valid_coarseOut,
    input  in_ready, count, valid_in, internal_valid,
    input  cbuf_rd_en, cbuf_rd_addr, cbuf_wr_en, cbuf_wr_addr
  );
endinterface

// File: rtl/dwt_level_sequencer.sv
// Multi-level DWT scheduler: level 0 from source, later levels from coarse buffer.
// Ports: clk, rst_n (sync, active-low), start, bus (master), level, busy, done, err.
// Optional: DWT_SEQ_DRAIN_TIMEOUT_EN enables a 32-cycle DRAIN watchdog driving err.
module dwt_level_sequencer #(
  parameter int N_SAMPLES = 16,
  parameter int LEVELS    = 3,
  parameter int CNT_W     = 5,
  parameter int ADDR_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  dwt_level_sequencer_if.master bus,
  output logic [1:0]           level,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int LW = CNT_W + 1;
  localparam logic [LW-1:0] N_W = LW'(N_SAMPLES);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        level_q, level_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [LW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              in_ready_q, in_ready_d;
  logic              valid_in_q, valid_in_d;
  logic              iv_q, iv_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [LW-1:0]     len, half, last;

`ifdef DWT_SEQ_DRAIN_TIMEOUT_EN
  logic [5:0]        wd_q, wd_d;
`endif

  assign len  = N_W >> level_q;
  assign half = len >> 1;
  assign last = len - LW'(1);

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    count_d    = count_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    valid_in_d = 1'b0;
    iv_d       = 1'b0;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;
`ifdef DWT_SEQ_DRAIN_TIMEOUT_EN
    wd_d       = '0;
`endif

    // buffer read has one cycle of latency
    if (rd_en_q) begin
      iv_d    = 1'b1;
      count_d = CNT_W'(rd_addr_q);
    end

    if ((state_q == LOAD || state_q == FEED ||
         state_q == DRAIN) &&
        bus.valid_coarseOut && wr_cnt_q < half) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ADDR_W'(wr_cnt_q);
      wr_cnt_d  = wr_cnt_q + LW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          level_d  = '0;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
        end
      end
      LOAD: begin
        if (bus.in_valid && in_ready_q) begin
          valid_in_d = 1'b1;
          count_d    = rd_cnt_q;
          rd_cnt_d   = rd_cnt_q + CNT_W'(1);
          if (LW'(rd_cnt_q) == last)
            state_d = DRAIN;
        end
      end
      FEED: begin
        if (LW'(rd_addr_q) == last)
          state_d = DRAIN;
        else
          rd_addr_d = rd_addr_q + ADDR_W'(1);
      end
      DRAIN: begin
        // a write landing this edge counts toward the exit
        if (wr_cnt_d == half) begin
          if (int'(level_q) < LEVELS - 1) begin
            state_d   = FEED;
            level_d   = level_q + 2'd1;
            rd_addr_d = '0;
            wr_cnt_d  = '0;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
`ifdef DWT_SEQ_DRAIN_TIMEOUT_EN
          wd_d = wd_q + 6'd1;
          if (wd_q == 6'd31) begin
            state_d = IDLE;
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == LOAD);
    rd_en_d    = (state_d == FEED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      level_q    <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      count_q    <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      in_ready_q <= 1'b0;
      valid_in_q <= 1'b0;
      iv_q       <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef DWT_SEQ_DRAIN_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      count_q    <= count_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      in_ready_q <= in_ready_d;
      valid_in_q <= valid_in_d;
      iv_q       <= iv_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef DWT_SEQ_DRAIN_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.valid_in       = valid_in_q;
  assign bus.internal_valid = iv_q;
  assign bus.count          = count_q;
  assign bus.cbuf_rd_en     = rd_en_q;
  assign bus.cbuf_rd_addr   = rd_addr_q;
  assign bus.cbuf_wr_en     = wr_en_q;
  assign bus.cbuf_wr_addr   = wr_addr_q;
  assign level              = level_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;

endmodule

// File: tb/tb_dwt_level_sequencer.sv
// Self-checking bench for dwt_level_sequencer with a behavioural
// datapath model (coarse every 2nd sample, 2-cycle latency).
`timescale 1ns/1ps
module tb_dwt_level_sequencer;
  localparam int N  = 16;
  localparam int LV = 3;
  localparam int CW = 5;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [1:0] level;
  logic busy, done, err;
  logic dp_pulse = 1'b0;
  logic inj = 1'b0;
  logic dp_skip_l0 = 1'b0;
  logic dp_drop = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sched[$];
  int vin_q[$], iv_q[$], iv_lv_q[$], iv_cyc_q[$], wr_q[$];
  int done_cnt = 0;
  int both_cnt = 0;
  int align_err = 0;
  int hold_err = 0;
  logic prev_rst = 1'b0;
  logic prev_rd_en = 1'b0;
  logic [AW-1:0] prev_rd_addr = '0;
  logic [CW-1:0] prev_count = '0;

  dwt_level_sequencer_if #(.CNT_W(CW), .ADDR_W(AW)) bus ();
  assign bus.valid_coarseOut = dp_pulse | inj;

  dwt_level_sequencer #(
    .N_SAMPLES(N), .LEVELS(LV), .CNT_W(CW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .level(level), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // datapath model: emits scheduled coarse pulses
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst_n) sched.delete();
    if (sched.size() > 0 && sched[0] == cyc) begin
      dp_pulse = 1'b1;
      void'(sched.pop_front());
    end else begin
      dp_pulse = 1'b0;
    end
  end

  // monitor + datapath sample capture
  always @(negedge clk) begin
    if (bus.valid_in) vin_q.push_back(int'(bus.count));
    if (bus.internal_valid) begin
      iv_q.push_back(int'(bus.count));
      iv_lv_q.push_back(int'(level));
      iv_cyc_q.push_back(cyc);
    end
    if (bus.cbuf_wr_en) wr_q.push_back(int'(bus.cbuf_wr_addr));
    if (done) done_cnt++;
    if (bus.valid_in && bus.internal_valid) both_cnt++;
    if (rst_n && prev_rst) begin
      if (bus.internal_valid !== prev_rd_en) align_err++;
      else if (bus.internal_valid &&
               bus.count !== CW'(prev_rd_addr)) align_err++;
      if (!bus.valid_in && !bus.internal_valid &&
          bus.count !== prev_count) hold_err++;
      if (bus.valid_in && bus.count[0] && !dp_skip_l0 &&
          !(dp_drop && int'(bus.count) == N - 1))
        sched.push_back(cyc + 2);
      if (bus.internal_valid && bus.count[0])
        sched.push_back(cyc + 2);
    end
    prev_rst     = rst_n;
    prev_rd_en   = rst_n ? bus.cbuf_rd_en : 1'b0;
    prev_rd_addr = bus.cbuf_rd_addr;
    prev_count   = bus.count;
  end

  function automatic string q2s(input int q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  function automatic string runs2s(input int q[$]);
    string s = "";
    int r = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0 && q[i] != q[i-1] + 1) begin
        s = {s, $sformatf("%0d ", r)};
        r = 0;
      end
      r++;
    end
    if (r > 0) s = {s, $sformatf("%0d ", r)};
    return s;
  endfunction

  // reference model: what a full transform must produce
  function automatic string exp_vin();
    int q[$];
    for (int k = 0; k < N; k++) q.push_back(k);
    return q2s(q);
  endfunction

  function automatic string exp_iv();
    int q[$];
    for (int l = 1; l < LV; l++)
      for (int k = 0; k < (N >> l); k++) q.push_back(k);
    return q2s(q);
  endfunction

  function automatic string exp_lv();
    int q[$];
    for (int l = 1; l < LV; l++)
      for (int k = 0; k < (N >> l); k++) q.push_back(l);
    return q2s(q);
  endfunction

  function automatic string exp_runs();
    int q[$];
    for (int l = 1; l < LV; l++) q.push_back(N >> l);
    return q2s(q);
  endfunction

  function automatic string exp_wr();
    int q[$];
    for (int l = 0; l < LV; l++)
      for (int k = 0; k < (N >> l) / 2; k++) q.push_back(k);
    return q2s(q);
  endfunction

  task automatic clear_rec();
    vin_q.delete(); iv_q.delete(); iv_lv_q.delete();
    iv_cyc_q.delete(); wr_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.valid_in, bus.internal_valid,
         bus.count} !== '0) begin
      errors++;
      $display("FAIL reset_stream: got %b/%b/%b/%0d want 0",
               bus.in_ready, bus.valid_in, bus.internal_valid,
               bus.count);
    end
    checks++;
    if ({bus.cbuf_rd_en, bus.cbuf_rd_addr, bus.cbuf_wr_en,
         bus.cbuf_wr_addr} !== '0) begin
      errors++;
      $display("FAIL reset_cbuf: got %b/%0d/%b/%0d want 0",
               bus.cbuf_rd_en, bus.cbuf_rd_addr,
               bus.cbuf_wr_en, bus.cbuf_wr_addr);
    end
    checks++;
    if ({level, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_status: lvl=%0d busy=%b done=%b err=%b want 0",
               level, busy, done, err);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    int t = 0;
    clear_rec();
    bus.in_valid = 1'b1;
    do_start();
    while (done !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nom_done: done=%b busy=%b want 1/0", done, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q2s(vin_q) != exp_vin()) begin
      errors++;
      $display("FAIL nom_vin: got %s want %s", q2s(vin_q), exp_vin());
    end
    checks++;
    if (q2s(iv_q) != exp_iv() || q2s(iv_lv_q) != exp_lv()) begin
      errors++;
      $display("FAIL nom_iv: got %s / %s want %s / %s",
               q2s(iv_q), q2s(iv_lv_q), exp_iv(), exp_lv());
    end
    checks++;
    if (runs2s(iv_cyc_q) != exp_runs()) begin
      errors++;
      $display("FAIL nom_iv_runs: got %s want %s",
               runs2s(iv_cyc_q), exp_runs());
    end
    checks++;
    if (q2s(wr_q) != exp_wr()) begin
      errors++;
      $display("FAIL nom_wr: got %s want %s", q2s(wr_q), exp_wr());
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nom_once: done_cnt=%0d busy=%b want 1/0",
               done_cnt, busy);
    end
  endtask

  task automatic test_gapped();
    int t = 0;
    clear_rec();
    bus.in_valid = 1'b0;
    do_start();
    while (t < 1000) begin
      @(posedge clk); #1 bus.in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      t++;
      if (done === 1'b1) break;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL gap_done: done=%b want 1 after %0d cycles", done, t);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (q2s(vin_q) != exp_vin()) begin
      errors++;
      $display("FAIL gap_vin: got %s want %s", q2s(vin_q), exp_vin());
    end
    checks++;
    if (q2s(iv_q) != exp_iv() || q2s(wr_q) != exp_wr()) begin
      errors++;
      $display("FAIL gap_later: iv %s wr %s want %s / %s",
               q2s(iv_q), q2s(wr_q), exp_iv(), exp_wr());
    end
  endtask

  task automatic test_reset_mid_feed();
    int t = 0;
    clear_rec();
    bus.in_valid = 1'b1;
    do_start();
    while (!(level == 2'd1 && bus.internal_valid &&
             int'(bus.count) == 3) && t < 500) begin
      @(negedge clk); t++;
    end
    checks++;
    if (!(level == 2'd1 && bus.internal_valid)) begin
      errors++;
      $display("FAIL rst_reach: lvl=%0d iv=%b want 1/1",
               level, bus.internal_valid);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.valid_in, bus.internal_valid, bus.count,
         bus.cbuf_rd_en, bus.cbuf_rd_addr, bus.cbuf_wr_en,
         bus.cbuf_wr_addr, level, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL rst_mid: rd=%b iv=%b cnt=%0d lvl=%0d busy=%b want 0",
               bus.cbuf_rd_en, bus.internal_valid, bus.count,
               level, busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL rst_nodone: done_cnt=%0d want 0", done_cnt);
    end
    test_nominal();
  endtask

  task automatic test_ignored();
    int t = 0;
    clear_rec();
    bus.in_valid = 1'b1;
    @(posedge clk); #1 inj = 1'b1;
    repeat (3) @(posedge clk);
    #1 inj = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (wr_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_idle: writes=%0d busy=%b want 0/0",
               wr_q.size(), busy);
    end
    do_start();
    while (t < 500) begin
      @(posedge clk); #1 start = (t == 5 || t == 30);
      @(negedge clk);
      t++;
      if (done === 1'b1) break;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (q2s(vin_q) != exp_vin() || q2s(iv_q) != exp_iv()) begin
      errors++;
      $display("FAIL ign_stream: vin %s iv %s want %s / %s",
               q2s(vin_q), q2s(iv_q), exp_vin(), exp_iv());
    end
    checks++;
    if (q2s(wr_q) != exp_wr() || done_cnt != 1) begin
      errors++;
      $display("FAIL ign_wr: wr %s done=%0d want %s / 1",
               q2s(wr_q), done_cnt, exp_wr());
    end
  endtask

  task automatic test_extra_coarse();
    int t = 0;
    clear_rec();
    dp_skip_l0 = 1'b1;
    bus.in_valid = 1'b1;
    do_start();
    inj = 1'b1;
    repeat (10) @(posedge clk);
    #1 inj = 1'b0;
    while (done !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    dp_skip_l0 = 1'b0;
    checks++;
    if (q2s(wr_q) != exp_wr()) begin
      errors++;
      $display("FAIL extra_wr: got %s want %s", q2s(wr_q), exp_wr());
    end
    checks++;
    if (q2s(iv_lv_q) != exp_lv() || done_cnt != 1) begin
      errors++;
      $display("FAIL extra_lvl: lv %s done=%0d want %s / 1",
               q2s(iv_lv_q), done_cnt, exp_lv());
    end
  endtask

  task automatic test_timeout();
    int t = 0;
    int c0 = 0;
    clear_rec();
    dp_drop = 1'b1;
    bus.in_valid = 1'b1;
    do_start();
`ifdef DWT_SEQ_DRAIN_TIMEOUT_EN
    while (!(bus.valid_in && int'(bus.count) == N - 1) && t < 200) begin
      @(negedge clk); t++;
    end
    c0 = cyc;
    t = 0;
    while (err !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (cyc - c0 != 32 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_fire: after %0d cyc done=%b busy=%b want 32/1/0",
               cyc - c0, done, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || bus.in_ready !== 1'b0 ||
        wr_q.size() != N / 2 - 1) begin
      errors++;
      $display("FAIL to_after: err=%b done=%b rdy=%b wr=%0d want 1/0/0/%0d",
               err, done, bus.in_ready, wr_q.size(), N / 2 - 1);
    end
`else
    repeat (100) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || err !== 1'b0 || level !== 2'd0 ||
        done_cnt != 0) begin
      errors++;
      $display("FAIL to_wait: busy=%b err=%b lvl=%0d done=%0d want 1/0/0/0",
               busy, err, level, done_cnt);
    end
    c0 = t;
`endif
    dp_drop = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_invariants();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL inv_both: both-high cycles %0d want 0", both_cnt);
    end
    checks++;
    if (align_err != 0) begin
      errors++;
      $display("FAIL inv_align: read/iv misalign %0d want 0", align_err);
    end
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("FAIL inv_hold: idle count changes %0d want 0", hold_err);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    test_reset();
    test_nominal();
    test_gapped();
    test_reset_mid_feed();
    test_ignored();
    test_extra_coarse();
    test_timeout();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
